tv80_alu16_seq: RTL and testbench
=================================

TV80_ALU16_SEQ -- requirements
Module: tv80_alu16_seq

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: reset_n  in  1  asynchronous active-low reset.
REQ-004 Port: start  in  1  request a 16-bit operation; sampled only when idle or done.
REQ-005 Port: op  in  2  operation: 00 ADD16, 01 ADC16, 10 SBC16, 11 treated as ADD16.
REQ-006 Port: opa / opb  in  16 each  operands A (HL) and B (rr).
REQ-007 Port: f_in  in  8  flag register at start (C=bit0, N=1, P/V=2, X=3, H=4, Y=5, Z=6, S=7).
REQ-008 Port: alu_op  out  4  ALU opcode (ADD 0000, ADC 0001, SBC 0011).
REQ-009 Port: alu_busa / alu_busb  out  8 each  ALU operand bytes.
REQ-010 Port: alu_f_in  out  8  flags presented to the ALU.
REQ-011 Port: alu_arith16 / alu_z16  out  1 each  ALU 16-bit flag-preserve and zero-chain controls.
REQ-012 Port: alu_q / alu_f_out  in  8 each  combinational ALU result and flags.
REQ-013 Port: busy  out  1  high in LO and HI states.
REQ-014 Port: done  out  1  one-cycle completion pulse.
REQ-015 Port: result  out  16  registered 16-bit result.
REQ-016 Port: f_out  out  8  registered final flags.

Function
REQ-017 FSM states IDLE, LO, HI, DONE; IDLE->LO on start; LO->HI; HI->DONE unconditionally; DONE->LO if start else IDLE.
REQ-018 On accepted start, opa, opb, op and f_in SHALL be latched; inputs are ignored thereafter until the next accept.
REQ-019 start in LO or HI SHALL be ignored (no queueing).
REQ-020 LO: alu_busa=opa[7:0], alu_busb=opb[7:0], alu_f_in=latched f_in; ADD16 uses alu_op 0000, ADC16 0001, SBC16 0011.
REQ-021 End of LO: alu_q captured into result[7:0]; alu_f_out captured into an internal flag register.
REQ-022 HI: alu_busa=opa[15:8], alu_busb=opb[15:8], alu_f_in=internal flag register; ADD16 uses 0001, ADC16 0001, SBC16 0011.
REQ-023 alu_arith16=1 in LO and HI for ADD16, else 0; alu_z16=1 only in HI for ADC16/SBC16.
REQ-024 End of HI: alu_q captured into result[15:8]; alu_f_out into f_out; done=1 during DONE only.
REQ-025 Latency: done high in the cycle following the 3rd rising edge after start is sampled; back-to-back throughput of one op per 3 cycles.
REQ-026 result and f_out SHALL hold their values until the next HI capture; result[7:0] updates at end of LO and may differ from the final result while busy.
REQ-027 In IDLE and DONE: alu_op=0000, alu_busa=alu_busb=00, alu_f_in=00, alu_arith16=alu_z16=0.

Reset
REQ-028 reset_n low SHALL force IDLE immediately, mid-operation included; busy=0, done=0, result=0000, f_out=00, latches cleared.
REQ-029 After reset release, the first operation SHALL require a fresh start.

Verification
REQ-030 ADD16 opa=0FFF opb=0001 f_in=00 -> result=1000, f_out=10 (H only; S/Z/P preserved).
REQ-031 ADC16 opa=FFFF opb=0000 f_in=01 -> result=0000, f_out=51 (Z,H,C).
REQ-032 SBC16 opa=8000 opb=0001 f_in=00 -> result=7FFF, f_out=3E (Y,H,X,V,N).
REQ-033 SBC16 1234-1234 f_in=00 -> 0000, f_out=42; SBC16 0100-0001 -> 00FF, Z=0.
REQ-034 start held high continuously -> ops accepted at IDLE then every DONE, busy pattern 1,1,0 repeating, one done per op; start pulses during busy -> ignored.
REQ-035 reset_n low during HI -> busy=0, done=0, result=0000, f_out=00 asynchronously; no done pulse after release.

Source files
------------

// File: rtl/tv80_alu16_seq.sv
// Two-pass 16-bit ADD/ADC/SBC sequencer around the external 8-bit TV80 ALU.
// The low byte is processed first, then the high byte with the chained flags.
//
// state  | meaning
// IDLE   | waiting for start, ALU drive parked at zero
// LO     | low bytes on the ALU buses, f_in as flags
// HI     | high bytes on the ALU buses, low-byte flags as flags
// DONE   | result/f_out valid, done pulse, new start may be accepted
module tv80_alu16_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic [7:0]  f_in,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_busa,
  output logic [7:0]  alu_busb,
  output logic [7:0]  alu_f_in,
  output logic        alu_arith16,
  output logic        alu_z16,
  input  logic [7:0]  alu_q,
  input  logic [7:0]  alu_f_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [7:0]  f_out
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [7:0]  opa_hi;
  logic [7:0]  opb_hi;

  // op 11 behaves as ADD16
  function automatic logic is_add16(input logic [1:0] o);
    return !(o == 2'b01 || o == 2'b10);
  endfunction

  function automatic logic [3:0] lo_opcode(input logic [1:0] o);
    case (o)
      2'b01:   return 4'b0001;
      2'b10:   return 4'b0011;
      default: return 4'b0000;
    endcase
  endfunction

  // high byte always consumes the low-byte carry
  function automatic logic [3:0] hi_opcode(input logic [1:0] o);
    return (o == 2'b10) ? 4'b0011 : 4'b0001;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      op_q        <= 2'b00;
      opa_hi      <= 8'h00;
      opb_hi      <= 8'h00;
      alu_op      <= 4'b0000;
      alu_busa    <= 8'h00;
      alu_busb    <= 8'h00;
      alu_f_in    <= 8'h00;
      alu_arith16 <= 1'b0;
      alu_z16     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= 16'h0000;
      f_out       <= 8'h00;
    end else begin
      case (state)
        S_LO: begin
          state        <= S_HI;
          result[7:0]  <= alu_q;
          alu_op       <= hi_opcode(op_q);
          alu_busa     <= opa_hi;
          alu_busb     <= opb_hi;
          // alu_f_in doubles as the internal low-byte flag register
          alu_f_in     <= alu_f_out;
          alu_z16      <= ~is_add16(op_q);
        end
        S_HI: begin
          state        <= S_DONE;
          result[15:8] <= alu_q;
          f_out        <= alu_f_out;
          busy         <= 1'b0;
          done         <= 1'b1;
          alu_op       <= 4'b0000;
          alu_busa     <= 8'h00;
          alu_busb     <= 8'h00;
          alu_f_in     <= 8'h00;
          alu_arith16  <= 1'b0;
          alu_z16      <= 1'b0;
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            state       <= S_LO;
            busy        <= 1'b1;
            op_q        <= op;
            opa_hi      <= opa[15:8];
            opb_hi      <= opb[15:8];
            alu_op      <= lo_opcode(op);
            alu_busa    <= opa[7:0];
            alu_busb    <= opb[7:0];
            alu_f_in    <= f_in;
            alu_arith16 <= is_add16(op);
            alu_z16     <= 1'b0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tv80_alu16_seq.sv
// Bench for tv80_alu16_seq: byte-level TV80 ALU stand-in plus a whole-word
// reference model for the 16-bit results and flags.
module tb_tv80_alu16_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] opa, opb;
  logic [7:0]  f_in;
  logic [3:0]  alu_op;
  logic [7:0]  alu_busa, alu_busb, alu_f_in;
  logic        alu_arith16, alu_z16;
  logic [7:0]  alu_q, alu_f_out;
  logic        busy, done;
  logic [15:0] result;
  logic [7:0]  f_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tv80_alu16_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .f_in(f_in), .alu_op(alu_op), .alu_busa(alu_busa), .alu_busb(alu_busb),
    .alu_f_in(alu_f_in), .alu_arith16(alu_arith16), .alu_z16(alu_z16),
    .alu_q(alu_q), .alu_f_out(alu_f_out), .busy(busy), .done(done),
    .result(result), .f_out(f_out)
  );

  // 8-bit TV80 ALU behaviour for ADD/ADC/SBC, returns {flags, q}
  function automatic logic [15:0] alu8(input logic [3:0] o, input logic [7:0] a, b, fi,
                                       input logic a16, z16);
    int c, s, h, sv;
    logic [7:0] q, f;
    logic sub;
    if (o != 4'b0000 && o != 4'b0001 && o != 4'b0011) return 16'h0000;
    sub = (o == 4'b0011);
    c = (o == 4'b0000) ? 0 : int'(fi[0]);
    if (sub) begin
      s  = int'(a) - int'(b) - c;
      h  = int'(a[3:0]) - int'(b[3:0]) - c;
      sv = int'($signed(a)) - int'($signed(b)) - c;
    end else begin
      s  = int'(a) + int'(b) + c;
      h  = int'(a[3:0]) + int'(b[3:0]) + c;
      sv = int'($signed(a)) + int'($signed(b)) + c;
    end
    q    = s[7:0];
    f    = 8'h00;
    f[0] = sub ? (s < 0) : (s > 255);
    f[1] = sub;
    f[2] = (sv < -128 || sv > 127);
    f[3] = q[3];
    f[4] = sub ? (h < 0) : (h > 15);
    f[5] = q[5];
    f[6] = (q == 8'h00) && (z16 ? fi[6] : 1'b1);
    f[7] = q[7];
    if (a16) begin
      f[7] = fi[7];
      f[6] = fi[6];
      f[2] = fi[2];
    end
    return {f, q};
  endfunction

  always_comb {alu_f_out, alu_q} = alu8(alu_op, alu_busa, alu_busb, alu_f_in, alu_arith16, alu_z16);

  // Whole-word expectation, returns {flags, result}
  function automatic logic [23:0] ref16(input logic [1:0] o, input logic [15:0] a, b,
                                        input logic [7:0] fi);
    int c, s, h, sv;
    logic [15:0] r;
    logic [7:0]  f;
    logic sub, add16;
    sub   = (o == 2'b10);
    add16 = !(o == 2'b01 || o == 2'b10);
    c = add16 ? 0 : int'(fi[0]);
    if (sub) begin
      s  = int'(a) - int'(b) - c;
      h  = int'(a[11:0]) - int'(b[11:0]) - c;
      sv = int'($signed(a)) - int'($signed(b)) - c;
    end else begin
      s  = int'(a) + int'(b) + c;
      h  = int'(a[11:0]) + int'(b[11:0]) + c;
      sv = int'($signed(a)) + int'($signed(b)) + c;
    end
    r    = s[15:0];
    f    = 8'h00;
    f[0] = sub ? (s < 0) : (s > 65535);
    f[1] = sub;
    f[2] = (sv < -32768 || sv > 32767);
    f[3] = r[11];
    f[4] = sub ? (h < 0) : (h > 4095);
    f[5] = r[13];
    f[6] = (r == 16'h0000);
    f[7] = r[15];
    if (add16) begin
      f[7] = fi[7];
      f[6] = fi[6];
      f[2] = fi[2];
    end
    return {f, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One isolated operation with junk on the inputs and start while busy
  task automatic run_op(input logic [1:0] o, input logic [15:0] a, b, input logic [7:0] fi);
    logic [23:0] e;
    logic        add16;
    logic [3:0]  lo_exp, hi_exp;
    e      = ref16(o, a, b, fi);
    add16  = !(o == 2'b01 || o == 2'b10);
    lo_exp = (o == 2'b01) ? 4'b0001 : (o == 2'b10) ? 4'b0011 : 4'b0000;
    hi_exp = (o == 2'b10) ? 4'b0011 : 4'b0001;
    start = 1'b1; op = o; opa = a; opb = b; f_in = fi;
    @(posedge clk); #1;
    start = 1'(($urandom & 1)); op = 2'($urandom); opa = 16'($urandom); opb = 16'($urandom);
    f_in = 8'($urandom);
    chk("lo_busy", busy, 1);
    chk("lo_busa", alu_busa, a[7:0]);
    chk("lo_busb", alu_busb, b[7:0]);
    chk("lo_fin", alu_f_in, fi);
    chk("lo_aluop", alu_op, lo_exp);
    chk("lo_arith16", alu_arith16, add16);
    chk("lo_z16", alu_z16, 0);
    @(posedge clk); #1;
    start = 1'b1;
    chk("hi_busy", busy, 1);
    chk("hi_done", done, 0);
    chk("hi_busa", alu_busa, a[15:8]);
    chk("hi_busb", alu_busb, b[15:8]);
    chk("hi_aluop", alu_op, hi_exp);
    chk("hi_arith16", alu_arith16, add16);
    chk("hi_z16", alu_z16, !add16);
    chk("hi_res_lo", result[7:0], e[7:0]);
    @(posedge clk); #1;
    start = 1'b0;
    chk("dn_done", done, 1);
    chk("dn_busy", busy, 0);
    chk("dn_result", result, e[15:0]);
    chk("dn_fout", f_out, e[23:16]);
    chk("dn_aluop", alu_op, 0);
    chk("dn_busab", {alu_busa, alu_busb, alu_f_in}, 0);
    chk("dn_ctl", {alu_arith16, alu_z16}, 0);
    @(posedge clk); #1;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_hold", {f_out, result}, e);
  endtask

  initial begin
    logic [23:0] e;
    logic [1:0]  o;
    logic [15:0] a, b;
    logic [7:0]  fi;

    reset_n = 1'b0; start = 1'b0; op = 2'b00; opa = 16'h0; opb = 16'h0; f_in = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {busy, done, result, f_out}, 0);
    chk("rst_alu", {alu_op, alu_busa, alu_busb, alu_f_in, alu_arith16, alu_z16}, 0);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rel_idle", {busy, done}, 0);

    run_op(2'b00, 16'h0FFF, 16'h0001, 8'h00);
    chk("v_add16", {f_out, result}, 24'h10_1000);
    run_op(2'b01, 16'hFFFF, 16'h0000, 8'h01);
    chk("v_adc16", {f_out, result}, 24'h51_0000);
    run_op(2'b10, 16'h8000, 16'h0001, 8'h00);
    chk("v_sbc16", {f_out, result}, 24'h3E_7FFF);
    run_op(2'b10, 16'h1234, 16'h1234, 8'h00);
    chk("v_sbc_zero", {f_out, result}, 24'h42_0000);
    run_op(2'b10, 16'h0100, 16'h0001, 8'h00);
    chk("v_sbc_nz", {f_out[6], result}, {1'b0, 16'h00FF});
    run_op(2'b11, 16'h7FFF, 16'h0001, 8'hC4);
    run_op(2'b01, 16'h7FFF, 16'h0000, 8'h01);

    for (int i = 0; i < 40; i++)
      run_op(2'($urandom), 16'($urandom), 16'($urandom), 8'($urandom));

    // start held high: one op per three cycles
    o = 2'($urandom); a = 16'($urandom); b = 16'($urandom); fi = 8'($urandom);
    e = ref16(o, a, b, fi);
    start = 1'b1; op = o; opa = a; opb = b; f_in = fi;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("bb_lo_busy", {busy, done}, 2'b10);
      @(posedge clk); #1;
      chk("bb_hi_busy", {busy, done}, 2'b10);
      @(posedge clk); #1;
      chk("bb_dn_busy", {busy, done}, 2'b01);
      chk("bb_result", {f_out, result}, e);
      if (k == 5) start = 1'b0;
      else begin
        o = 2'($urandom); a = 16'($urandom); b = 16'($urandom); fi = 8'($urandom);
        e = ref16(o, a, b, fi);
        op = o; opa = a; opb = b; f_in = fi;
      end
    end
    @(posedge clk); #1;
    chk("bb_stop", {busy, done}, 0);

    // reset in the HI cycle
    run_op(2'b00, 16'h0FFF, 16'h0001, 8'h00);
    start = 1'b1; op = 2'b01; opa = 16'h1111; opb = 16'h2222; f_in = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_state", {busy, done, result, f_out}, 0);
    chk("mid_rst_alu", {alu_op, alu_busa, alu_busb, alu_f_in, alu_arith16, alu_z16}, 0);
    @(negedge clk) reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("post_rst_quiet", {busy, done}, 0);
    end
    run_op(2'b10, 16'h8000, 16'h0001, 8'h00);
    chk("post_rst_op", {f_out, result}, 24'h3E_7FFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
